// File: rtl/peri_bridge_if.sv
// Peripheral request/response bus plus the sel/ack slave bus behind peri_bridge.
// master = core and slave-device side, slave = the bridge itself.
interface peri_bridge_if #(
  parameter int NUM_SLAVES = 4,
  parameter int SLAVE_AW   = 12
);
  logic                     peri_req;
  logic [31:0]              peri_addr;
  logic                     peri_write;
  logic [3:0]               peri_be;
  logic [31:0]              peri_wdata;
  logic                     peri_gnt;
  logic                     peri_rvalid;
  logic [31:0]              peri_rdata;
  logic                     peri_err;
  logic [NUM_SLAVES-1:0]    slv_sel;
  logic [SLAVE_AW-1:0]      slv_addr;
  logic                     slv_we;
  logic [3:0]               slv_be;
  logic [31:0]              slv_wdata;
  logic [NUM_SLAVES-1:0]    slv_ack;
  logic [NUM_SLAVES*32-1:0] slv_rdata;

  modport master (
    output peri_req, peri_addr, peri_write, peri_be, peri_wdata, slv_ack, slv_rdata,
    input  peri_gnt, peri_rvalid, peri_rdata, peri_err,
           slv_sel, slv_addr, slv_we, slv_be, slv_wdata
  );

  modport slave (
    input  peri_req, peri_addr, peri_write, peri_be, peri_wdata, slv_ack, slv_rdata,
    output peri_gnt, peri_rvalid, peri_rdata, peri_err,
           slv_sel, slv_addr, slv_we, slv_be, slv_wdata
  );
endinterface

// File: rtl/peri_bridge.sv
// Peripheral bridge: decodes fixed windows and runs one sel/ack transaction at a time.
// Optional ack timeout is built when PERI_BRIDGE_TIMEOUT_EN is defined.
module peri_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter int          SLAVE_AW       = 12,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC0FFE
) (
  input logic          clk,
  input logic          rst,
  peri_bridge_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for peri_req, only point where a grant can happen
  // ACCESS | slave selected, waiting for its ack (or timeout)
  // RESP   | one-cycle response pulse towards the core
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int          IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [32:0] MAP_LIMIT = 33'(NUM_SLAVES) << SLAVE_AW;

  state_t              r_state, w_state_nxt;
  logic [SLAVE_AW-1:0] r_addr;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_gnt;
  logic                w_mapped;
  logic [IDX_W-1:0]    w_idx;
  logic                w_ack;
  logic                w_timeout;
  logic [31:0]         w_slv_rdata;

  // Any address bit above the index field makes the request unmapped.
  assign w_mapped    = {1'b0, bus.peri_addr} < MAP_LIMIT;
  assign w_idx       = IDX_W'(bus.peri_addr >> SLAVE_AW);
  assign w_gnt       = bus.peri_req && (r_state == IDLE) && !rst;
  assign w_ack       = bus.slv_ack[r_idx];
  assign w_slv_rdata = bus.slv_rdata[32*r_idx +: 32];

`ifdef PERI_BRIDGE_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; an ack in that cycle still wins.
  assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                              r_cnt <= '0;
    else if (w_gnt)                       r_cnt <= '0;
    else if (r_state == ACCESS && !w_ack) r_cnt <= r_cnt + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.peri_gnt    = w_gnt;
    bus.peri_rvalid = 1'b0;
    bus.peri_err    = 1'b0;
    bus.slv_sel     = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt) w_state_nxt = w_mapped ? ACCESS : RESP;
      end
      ACCESS: begin
        bus.slv_sel = NUM_SLAVES'(1) << r_idx;
        if (w_ack || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        bus.peri_rvalid = 1'b1;
        bus.peri_err    = r_err;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_gnt) begin
      r_addr  <= bus.peri_addr[SLAVE_AW-1:0];
      r_we    <= bus.peri_write;
      r_be    <= bus.peri_be;
      r_wdata <= bus.peri_wdata;
      r_idx   <= w_idx;
      r_err   <= !w_mapped;
      if (!w_mapped) r_rdata <= ERR_RDATA;
    end else if (r_state == ACCESS) begin
      if (w_ack) begin
        r_rdata <= w_slv_rdata;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= ERR_RDATA;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.slv_addr   = r_addr;
  assign bus.slv_we     = r_we;
  assign bus.slv_be     = r_be;
  assign bus.slv_wdata  = r_wdata;
  assign bus.peri_rdata = r_rdata;
endmodule

// File: tb/tb_peri_bridge.sv
// Scoreboard bench for peri_bridge: responses and slave-side accesses are queued at grant
// and compared when the DUT produces them.
module tb_peri_bridge;
  localparam int          NS     = 4;
  localparam int          AW     = 12;
  localparam int          TMO    = 8;
  localparam logic [31:0] ERR_RD = 32'hBADC0FFE;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [NS-1:0] sel;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  rsp_t mon_e;
  acc_t cur;

  int          s_wait  = 0;
  bit          s_never = 1'b0;
  logic [NS-1:0] s_noise = '0;
  logic [31:0] s_data[NS];
  int          acc_cyc = 0;

  peri_bridge_if #(.NUM_SLAVES(NS), .SLAVE_AW(AW)) bus ();

  peri_bridge #(
    .NUM_SLAVES(NS), .SLAVE_AW(AW), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR_RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bus.slv_rdata = {s_data[3], s_data[2], s_data[1], s_data[0]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave devices: ack after s_wait wait cycles, verify select and hold of request fields.
  always @(negedge clk) begin
    if (bus.slv_sel != '0) begin
      acc_cyc++;
      if (acc_cyc == 1) begin
        if (acc_q.size() == 0) begin
          chk("sel_unexpected", 64'(bus.slv_sel), 64'd0);
        end else begin
          cur = acc_q.pop_front();
          chk("slv_sel",   64'(bus.slv_sel),   64'(cur.sel));
          chk("slv_addr",  64'(bus.slv_addr),  64'(cur.addr));
          chk("slv_we",    64'(bus.slv_we),    64'(cur.we));
          chk("slv_be",    64'(bus.slv_be),    64'(cur.be));
          chk("slv_wdata", 64'(bus.slv_wdata), 64'(cur.wdata));
        end
      end else begin
        chk("sel_hold",   64'(bus.slv_sel),   64'(cur.sel));
        chk("addr_hold",  64'(bus.slv_addr),  64'(cur.addr));
        chk("we_hold",    64'(bus.slv_we),    64'(cur.we));
        chk("be_hold",    64'(bus.slv_be),    64'(cur.be));
        chk("wdata_hold", 64'(bus.slv_wdata), 64'(cur.wdata));
      end
      bus.slv_ack = (!s_never && acc_cyc == s_wait + 1) ? (bus.slv_sel | s_noise) : s_noise;
    end else begin
      acc_cyc     = 0;
      bus.slv_ack = s_noise;
    end
  end

  always @(negedge clk) begin
    if (bus.peri_rvalid) begin
      if (rsp_q.size() == 0) begin
        chk("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = rsp_q.pop_front();
        chk("rdata",   64'(bus.peri_rdata), 64'(mon_e.rdata));
        chk("err",     64'(bus.peri_err),   64'(mon_e.err));
        chk("latency", 64'(cyc),            64'(mon_e.due));
      end
    end else if (!rst && bus.peri_err) begin
      chk("err_outside_resp", 64'(bus.peri_err), 64'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the grant edge.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [NS-1:0] esel,
                       input logic [31:0] erd, input logic eerr, input int lat,
                       input bit exp_rsp, input bit hold, output int t_gnt);
    bit   got;
    rsp_t r;
    acc_t a;
    got = 1'b0;
    t_gnt = -1;
    bus.peri_req   = 1'b1;
    bus.peri_addr  = addr;
    bus.peri_write = wr;
    bus.peri_be    = be;
    bus.peri_wdata = wd;
    for (int n = 0; n < 50 && !got; n++) begin
      #1;
      if (bus.peri_gnt) begin
        got   = 1'b1;
        t_gnt = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      chk("gnt_timeout", 64'd0, 64'd1);
      bus.peri_req = 1'b0;
    end else begin
      if (exp_rsp) begin
        r.rdata = erd;
        r.err   = eerr;
        r.due   = t_gnt + lat;
        rsp_q.push_back(r);
      end
      if (esel != '0) begin
        a.sel   = esel;
        a.addr  = addr[AW-1:0];
        a.we    = wr;
        a.be    = be;
        a.wdata = wd;
        acc_q.push_back(a);
      end
      @(negedge clk);
      if (!hold) bus.peri_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      chk("rsp_pending", 64'(rsp_q.size()), 64'd0);
      rsp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t1, t2;
    for (int i = 0; i < NS; i++) s_data[i] = 32'hCAFE0000 + i;
    bus.peri_req   = 1'b1;
    bus.peri_addr  = 32'h0000_1000;
    bus.peri_write = 1'b0;
    bus.peri_be    = 4'hF;
    bus.peri_wdata = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt",    64'(bus.peri_gnt),    64'd0);
    chk("rst_rvalid", 64'(bus.peri_rvalid), 64'd0);
    chk("rst_err",    64'(bus.peri_err),    64'd0);
    chk("rst_sel",    64'(bus.slv_sel),     64'd0);
    chk("rst_we",     64'(bus.slv_we),      64'd0);
    chk("rst_addr",   64'(bus.slv_addr),    64'd0);
    chk("rst_be",     64'(bus.slv_be),      64'd0);
    chk("rst_wdata",  64'(bus.slv_wdata),   64'd0);
    chk("rst_rdata",  64'(bus.peri_rdata),  64'd0);
    bus.peri_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // read slave 1, immediate ack
    issue(32'h0000_1010, 1'b0, 4'hF, 32'h0, 4'b0010, 32'hCAFE0001, 1'b0, 2, 1'b1, 1'b0, t1);
    wait_idle();

    // write slave 3 with three wait cycles and spurious acks from other slaves
    s_wait  = 3;
    s_noise = 4'b0111;
    issue(32'h0000_3004, 1'b1, 4'b0011, 32'h1234_5678, 4'b1000, 32'hCAFE0003, 1'b0, 5,
          1'b1, 1'b0, t1);
    wait_idle();
    s_noise = '0;
    s_wait  = 0;

    // unmapped: first address past the last window, then a high address bit
    issue(32'h0000_4000, 1'b0, 4'hF, 32'h0, 4'b0000, ERR_RD, 1'b1, 1, 1'b1, 1'b0, t1);
    wait_idle();
    issue(32'h8000_0010, 1'b1, 4'hF, 32'h5555_AAAA, 4'b0000, ERR_RD, 1'b1, 1, 1'b1, 1'b0, t1);
    wait_idle();
    chk("rdata_hold", 64'(bus.peri_rdata), 64'(ERR_RD));

    // back-to-back with peri_req held high
    issue(32'h0000_0020, 1'b0, 4'hF, 32'h0, 4'b0001, 32'hCAFE0000, 1'b0, 2, 1'b1, 1'b1, t1);
    issue(32'h0000_2040, 1'b0, 4'hF, 32'h0, 4'b0100, 32'hCAFE0002, 1'b0, 2, 1'b1, 1'b0, t2);
    chk("b2b_gnt_cycle", 64'(t2), 64'(t1 + 3));
    wait_idle();

`ifdef PERI_BRIDGE_TIMEOUT_EN
    s_never = 1'b1;
    issue(32'h0000_2000, 1'b0, 4'hF, 32'h0, 4'b0100, ERR_RD, 1'b1, TMO + 1, 1'b1, 1'b0, t1);
    wait_idle();
    s_never = 1'b0;
    s_wait  = TMO - 1;
    issue(32'h0000_2008, 1'b0, 4'hF, 32'h0, 4'b0100, 32'hCAFE0002, 1'b0, TMO + 1,
          1'b1, 1'b0, t1);
    wait_idle();
    s_wait = 0;
`endif

    // reset while slave 0 is selected
    s_never = 1'b1;
    issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, 4'b0001, 32'h0, 1'b0, 0, 1'b0, 1'b0, t1);
    #1;
    chk("pre_rst_sel", 64'(bus.slv_sel), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_sel",    64'(bus.slv_sel),     64'd0);
    chk("post_rst_rvalid", 64'(bus.peri_rvalid), 64'd0);
    s_never = 1'b0;
    repeat (3) @(negedge clk);
    issue(32'h0000_3FFC, 1'b0, 4'hF, 32'h0, 4'b1000, 32'hCAFE0003, 1'b0, 2, 1'b1, 1'b0, t1);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/peri_bridge.md
Name: peri_bridge

Overview:
- Downstream of the core complex's peripheral port. Consumes the `peri_req`/`peri_addr`/`peri_write`/`peri_be`/`peri_wdata` request and produces `peri_gnt`/`peri_rvalid`/`peri_rdata`.
- Decodes the peripheral-relative address into one of NUM_SLAVES fixed 2^SLAVE_AW-byte windows.
- Runs one outstanding transaction at a time against a simple sel/ack slave bus.
- Returns an error response for unmapped addresses and, optionally, for slaves that never respond.

Parameters:
- NUM_SLAVES, 4, number of slave windows; power of two, 1..16.
- SLAVE_AW, 12, byte-address bits per window (4 KiB windows).
- TIMEOUT_CYCLES, 255, ACCESS cycles without ack before a timeout error; 1..65535; used only with the timeout feature.
- ERR_RDATA, 32'hBADC0FFE, read data returned on any error response.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset
- `peri_req`  in  1  request, offset already removed by upstream
- `peri_addr`  in  32  byte address relative to peripheral base
- `peri_write`  in  1  1=write
- `peri_be`  in  4  byte enables
- `peri_wdata`  in  32  write data
- `peri_gnt`  out  1  request accepted
- `peri_rvalid`  out  1  response valid, one-cycle pulse
- `peri_rdata`  out  32  response read data
- `peri_err`  out  1  error qualifier, valid with `peri_rvalid`
- `slv_sel`  out  NUM_SLAVES  one-hot slave select
- `slv_addr`  out  SLAVE_AW  byte offset inside window
- `slv_we`  out  1  write strobe qualifier
- `slv_be`  out  4  byte enables
- `slv_wdata`  out  32  write data
- `slv_ack`  in  NUM_SLAVES  per-slave completion
- `slv_rdata`  in  NUM_SLAVES*32  per-slave read data; slave i occupies bits [32i+31:32i]

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; `peri_gnt`, `peri_rvalid`, `peri_err`, `slv_sel`, `slv_we` all 0; `slv_addr`, `slv_be`, `slv_wdata`, `peri_rdata` all 0; timeout counter 0.
- Decode: idx = `peri_addr`[SLAVE_AW +: log2(NUM_SLAVES)]. Mapped iff `peri_addr` < NUM_SLAVES << SLAVE_AW (bits above the index field are zero).
- `peri_gnt` = `peri_req` && state==IDLE && !`rst`. It is combinational; this is the only acceptance point.
- IDLE:
  - On grant, register addr offset, `peri_write`, `peri_be`, `peri_wdata`, idx and the mapped flag.
  - Mapped → ACCESS. Unmapped → RESP with error.
- ACCESS:
  - `slv_sel`[idx]=1; `slv_addr`, `slv_we`, `slv_be`, `slv_wdata` are driven from registers and held stable throughout.
  - On `slv_ack`[idx]=1: capture `slv_rdata`[idx] into the response register (writes capture the same value, which is don't-care to the core). Go to RESP with err=0. `slv_sel` drops the next cycle.
  - `slv_ack` bits of non-selected slaves are ignored.
  - An ack in the same cycle the timeout expires wins (no error).
- RESP:
  - `peri_rvalid`=1 for exactly one cycle with registered `peri_rdata`/`peri_err`; then IDLE.
  - On error, `peri_rdata`=ERR_RDATA and `peri_err`=1.
  - `peri_req` held high during ACCESS/RESP is not granted; it is granted the cycle state returns to IDLE.
- Latency from grant cycle T:
  - Mapped with immediate ack: ACCESS at T+1, `peri_rvalid` at T+2.
  - Each extra wait cycle of the slave adds 1.
  - Unmapped: `peri_rvalid` at T+1.
- Outside RESP, `peri_rvalid`=0 and `peri_err`=0; `peri_rdata` holds its last value.
- Reset mid-transaction: abort next edge → IDLE. No `peri_rvalid` is issued and `slv_sel` is 0 from the next cycle. Slave side effects already caused are not undone.
- Throughput: at most one transaction per 3 cycles (mapped) or 2 cycles (unmapped).

Optional Feature:
- Macro `PERI_BRIDGE_TIMEOUT_EN`, defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, go to RESP with `peri_err`=1 and `peri_rdata`=ERR_RDATA; `slv_sel` drops.
- Undefined:
  - No counter is built and TIMEOUT_CYCLES is ignored.
  - ACCESS waits indefinitely for ack.

Test Plan:
- Read slave 1: `peri_addr`=32'h0000_1010, read; slave 1 acks the first ACCESS cycle with 32'hCAFE0001 → `slv_sel`=4'b0010, `slv_addr`=12'h010; `peri_rvalid` 2 cycles after gnt with `peri_rdata`=32'hCAFE0001, `peri_err`=0.
- Write slave 3: `peri_addr`=32'h0000_3004, `peri_be`=4'b0011, `peri_wdata`=32'h1234_5678; ack after 3 wait cycles → `slv_we`=1 with `slv_be`/`slv_wdata` stable all 4 ACCESS cycles; `peri_rvalid` 5 cycles after gnt, `peri_err`=0.
- Unmapped: `peri_addr`=32'h0000_4000 → no `slv_sel` ever; `peri_rvalid` 1 cycle after gnt, `peri_rdata`=32'hBADC0FFE, `peri_err`=1.
- Back-to-back: `peri_req` held high for two reads to slaves 0 and 2, each acking immediately → second gnt on the cycle after the first `peri_rvalid`; no gnt in ACCESS/RESP; both responses correct and in order.
- Timeout (`PERI_BRIDGE_TIMEOUT_EN`, TIMEOUT_CYCLES=8): slave 2 never acks → `peri_rvalid` 9 cycles after gnt with `peri_err`=1 and ERR_RDATA. Repeat with ack exactly on the 8th ACCESS cycle → normal response with `peri_err`=0.
- Reset mid-ACCESS: assert `rst` for 1 cycle while `slv_sel`=4'b0001 → `slv_sel`=0 and state IDLE next cycle, no `peri_rvalid`; a following request is granted normally.
